// File: rtl/clock_tx_fmt.sv
// Formats the current time and alarm status as an ASCII line ("MM:SS s\r\n") for the UART on each one-second strobe.
// Define ALARM_ECHO_EN to append " AM:AS" (the alarm time) after the status character.
module clock_tx_fmt (
    input  logic       clk,
    input  logic       rst,
    input  logic       oneSecStrb,
    input  logic [3:0] di_Mtens,
    input  logic [3:0] di_Mones,
    input  logic [3:0] di_Stens,
    input  logic [3:0] di_Sones,
    input  logic [3:0] di_AMtens,
    input  logic [3:0] di_AMones,
    input  logic [3:0] di_AStens,
    input  logic [3:0] di_ASones,
    input  logic       dicAlarmArmed,
    input  logic       dicAlarmTrig,
    input  logic       tx_busy,
    output logic       tx_data_rdy,
    output logic [7:0] tx_data,
    output logic       tx_active
);

    // Handshake: a byte is accepted by the transmitter when tx_data_rdy is high and tx_busy is low.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        GUARD = 2'd2,
        WAIT  = 2'd3
    } state_t;

`ifdef ALARM_ECHO_EN
    localparam logic [3:0] LAST_IDX = 4'd14;
`else
    localparam logic [3:0] LAST_IDX = 4'd8;
`endif

    state_t     state;
    state_t     state_nxt;
    logic [3:0] idx;
    logic [3:0] idx_nxt;
    logic       pending;
    logic       pending_nxt;
    logic       take_snap;
    logic       accept;
    logic       last_byte;

    logic       tx_data_rdy_nxt;
    logic [7:0] tx_data_nxt;
    logic       tx_active_nxt;
    logic [7:0] msg_byte;

    logic [3:0] snap_mt;
    logic [3:0] snap_mo;
    logic [3:0] snap_st;
    logic [3:0] snap_so;
    logic       snap_trig;
    logic       snap_armed;
    logic [7:0] status_char;

    function automatic logic [7:0] enc_digit(input logic [3:0] d);
        return (d <= 4'd9) ? (8'h30 | {4'h0, d}) : 8'h3F;
    endfunction

    assign accept    = (state == SEND) && !tx_busy;
    assign last_byte = (idx == LAST_IDX);

    // State register, byte index and pending flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= 4'd0;
            pending <= 1'b0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            pending <= pending_nxt;
        end
    end

    // Next-state logic; a strobe on the final WAIT edge restarts just like a pending one
    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        pending_nxt = pending;
        take_snap   = 1'b0;
        if (oneSecStrb && (state != IDLE)) pending_nxt = 1'b1;
        case (state)
            IDLE: begin
                if (oneSecStrb) begin
                    state_nxt = SEND;
                    idx_nxt   = 4'd0;
                    take_snap = 1'b1;
                end
            end
            SEND: begin
                if (!tx_busy) state_nxt = GUARD;
            end
            GUARD: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                if (!tx_busy) begin
                    if (!last_byte) begin
                        idx_nxt   = idx + 4'd1;
                        state_nxt = SEND;
                    end else if (pending || oneSecStrb) begin
                        idx_nxt     = 4'd0;
                        state_nxt   = SEND;
                        take_snap   = 1'b1;
                        pending_nxt = 1'b0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic, registered below
    always_comb begin
        tx_data_rdy_nxt = accept;
        tx_data_nxt     = accept ? msg_byte : tx_data;
        tx_active_nxt   = (state_nxt != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_data_rdy <= 1'b0;
            tx_data     <= 8'h00;
            tx_active   <= 1'b0;
        end else begin
            tx_data_rdy <= tx_data_rdy_nxt;
            tx_data     <= tx_data_nxt;
            tx_active   <= tx_active_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            snap_mt    <= 4'd0;
            snap_mo    <= 4'd0;
            snap_st    <= 4'd0;
            snap_so    <= 4'd0;
            snap_trig  <= 1'b0;
            snap_armed <= 1'b0;
        end else if (take_snap) begin
            snap_mt    <= di_Mtens;
            snap_mo    <= di_Mones;
            snap_st    <= di_Stens;
            snap_so    <= di_Sones;
            snap_trig  <= dicAlarmTrig;
            snap_armed <= dicAlarmArmed;
        end
    end

    assign status_char = snap_trig  ? 8'h21 :
                         snap_armed ? 8'h41 : 8'h2D;

`ifdef ALARM_ECHO_EN
    logic [3:0] snap_amt;
    logic [3:0] snap_amo;
    logic [3:0] snap_ast;
    logic [3:0] snap_aso;

    always_ff @(posedge clk) begin
        if (rst) begin
            snap_amt <= 4'd0;
            snap_amo <= 4'd0;
            snap_ast <= 4'd0;
            snap_aso <= 4'd0;
        end else if (take_snap) begin
            snap_amt <= di_AMtens;
            snap_amo <= di_AMones;
            snap_ast <= di_AStens;
            snap_aso <= di_ASones;
        end
    end

    always_comb begin
        msg_byte = 8'h00;
        case (idx)
            4'd0:  msg_byte = enc_digit(snap_mt);
            4'd1:  msg_byte = enc_digit(snap_mo);
            4'd2:  msg_byte = 8'h3A;
            4'd3:  msg_byte = enc_digit(snap_st);
            4'd4:  msg_byte = enc_digit(snap_so);
            4'd5:  msg_byte = 8'h20;
            4'd6:  msg_byte = status_char;
            4'd7:  msg_byte = 8'h20;
            4'd8:  msg_byte = enc_digit(snap_amt);
            4'd9:  msg_byte = enc_digit(snap_amo);
            4'd10: msg_byte = 8'h3A;
            4'd11: msg_byte = enc_digit(snap_ast);
            4'd12: msg_byte = enc_digit(snap_aso);
            4'd13: msg_byte = 8'h0D;
            4'd14: msg_byte = 8'h0A;
            default: msg_byte = 8'h00;
        endcase
    end
`else
    logic unused_alarm_digits;
    assign unused_alarm_digits = ^{di_AMtens, di_AMones, di_AStens, di_ASones};

    always_comb begin
        msg_byte = 8'h00;
        case (idx)
            4'd0: msg_byte = enc_digit(snap_mt);
            4'd1: msg_byte = enc_digit(snap_mo);
            4'd2: msg_byte = 8'h3A;
            4'd3: msg_byte = enc_digit(snap_st);
            4'd4: msg_byte = enc_digit(snap_so);
            4'd5: msg_byte = 8'h20;
            4'd6: msg_byte = status_char;
            4'd7: msg_byte = 8'h0D;
            4'd8: msg_byte = 8'h0A;
            default: msg_byte = 8'h00;
        endcase
    end
`endif

endmodule
